// File: rtl/dsp_pipe.sv
// dsp_pipe: 3-stage pre-add/multiply/post-add pipeline with valid/ready flow control.
// Define DSP_PIPE_SAT_EN to saturate the post-add and expose the ovf flag.
module dsp_pipe #(
  parameter int A_W  = 18,
  parameter int BD_W = 18,
  parameter int C_W  = 48,
  parameter int P_W  = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [A_W-1:0]  a,
  input  logic [BD_W-1:0] b,
  input  logic [BD_W-1:0] d,
  input  logic [C_W-1:0]  c,
  input  logic [2:0]      opmode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [P_W-1:0]  p
`ifdef DSP_PIPE_SAT_EN
  ,
  output logic            ovf
`endif
);
  logic stall, v1, v2, v3;
  logic signed [BD_W:0] pre_n, pre1;
  logic signed [A_W-1:0] a1;
  logic signed [C_W-1:0] c1, c2;
  logic [2:0] op1, op2;
  logic signed [P_W-1:0] m2, p_r, x, res;
  assign stall = v3 & ~out_ready;
  assign in_ready = ~stall;
  assign out_valid = v3;
  assign p = p_r;
  always_comb pre_n = opmode[0] ? (BD_W+1)'($signed(d)) - (BD_W+1)'($signed(b))
                                : (BD_W+1)'($signed(d)) + (BD_W+1)'($signed(b));
  // accumulate feeds back whatever p last loaded, consumed or not
  always_comb x = op2[2] ? p_r : P_W'(c2);
`ifdef DSP_PIPE_SAT_EN
  logic signed [P_W:0] wide;
  logic sat;
  always_comb begin
    wide = op2[1] ? (P_W+1)'(m2) - (P_W+1)'(x) : (P_W+1)'(m2) + (P_W+1)'(x);
    sat = wide[P_W] != wide[P_W-1];
    res = sat ? (wide[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}}) : wide[P_W-1:0];
  end
`else
  always_comb res = op2[1] ? m2 - x : m2 + x;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      pre1 <= '0;
      a1 <= '0;
      c1 <= '0;
      c2 <= '0;
      op1 <= '0;
      op2 <= '0;
      m2 <= '0;
      p_r <= '0;
`ifdef DSP_PIPE_SAT_EN
      ovf <= 1'b0;
`endif
    end else if (!stall) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        pre1 <= pre_n;
        a1 <= a;
        c1 <= c;
        op1 <= opmode;
      end
      if (v1) begin
        m2 <= P_W'(pre1) * P_W'(a1);
        c2 <= c1;
        op2 <= op1;
      end
      if (v2) begin
        p_r <= res;
`ifdef DSP_PIPE_SAT_EN
        ovf <= sat;
`endif
      end
    end
endmodule
